// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes ecall/ebreak/mret/timer interrupt, stalls the
// pipeline while mepc/mstatus/mcause are written, then redirects fetch for one cycle.
module trap_ctrl #(
  parameter int CPU_WIDTH      = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ecall_i,
  input  logic                      ebreak_i,
  input  logic                      mret_i,
  input  logic [CPU_WIDTH-1:0]      inst_addr_i,
  input  logic                      int_flag_i,
  input  logic                      pipe_busy_i,
  input  logic [CPU_WIDTH-1:0]      csr_mtvec_i,
  input  logic [CPU_WIDTH-1:0]      csr_mepc_i,
  input  logic [CPU_WIDTH-1:0]      csr_mstatus_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [CPU_WIDTH-1:0]      csr_wdata_o,
  output logic                      client_hold_flag_o,
  output logic                      client_int_assert_o,
  output logic [CPU_WIDTH-1:0]      client_int_addr_o
);

  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);

  localparam logic [CPU_WIDTH-1:0] CAUSE_ECALL  = CPU_WIDTH'(11);
  localparam logic [CPU_WIDTH-1:0] CAUSE_EBREAK = CPU_WIDTH'(3);
  localparam logic [CPU_WIDTH-1:0] CAUSE_IRQ    = {1'b1, {(CPU_WIDTH-4){1'b0}}, 3'd7};

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    MEPC,
    MSTATUS,
    MCAUSE,
    ASSERT,
    MRET_ST,
    MRET_AS
  } state_t;

  state_t state;
  state_t state_next;

  logic                 irq_pend;
  logic [CPU_WIDTH-1:0] cause_r;
  logic [CPU_WIDTH-1:0] epc_r;
  logic [CPU_WIDTH-1:0] mstatus_r;

  logic take_ecall;
  logic take_ebreak;
  logic take_mret;
  logic take_irq;
  logic take_trap;
  logic accept;

  logic [CPU_WIDTH-1:0] trap_mstatus;
  logic [CPU_WIDTH-1:0] mret_mstatus;

  // Event arbitration: only in IDLE with a quiet pipeline, ecall > ebreak > mret > irq.
  always_comb begin
    take_ecall  = 1'b0;
    take_ebreak = 1'b0;
    take_mret   = 1'b0;
    take_irq    = 1'b0;
    if (state == IDLE && !pipe_busy_i) begin
      if (ecall_i) begin
        take_ecall = 1'b1;
      end else if (ebreak_i) begin
        take_ebreak = 1'b1;
      end else if (mret_i) begin
        take_mret = 1'b1;
      end else if (irq_pend && csr_mstatus_i[MIE_BIT]) begin
        take_irq = 1'b1;
      end
    end
  end

  assign take_trap = take_ecall | take_ebreak | take_irq;
  assign accept    = take_trap | take_mret;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take_trap) begin
          state_next = MEPC;
        end else if (take_mret) begin
          state_next = MRET_ST;
        end
      end
      MEPC:    state_next = MSTATUS;
      MSTATUS: state_next = MCAUSE;
      MCAUSE:  state_next = ASSERT;
      ASSERT:  state_next = IDLE;
      MRET_ST: state_next = MRET_AS;
      MRET_AS: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A new pulse wins over the clear so a request arriving on the take cycle survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pend <= 1'b0;
    end else if (int_flag_i) begin
      irq_pend <= 1'b1;
    end else if (take_irq) begin
      irq_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cause_r   <= '0;
      epc_r     <= '0;
      mstatus_r <= '0;
    end else if (accept) begin
      mstatus_r <= csr_mstatus_i;
      if (take_trap) begin
        epc_r <= inst_addr_i;
        if (take_ecall) begin
          cause_r <= CAUSE_ECALL;
        end else if (take_ebreak) begin
          cause_r <= CAUSE_EBREAK;
        end else begin
          cause_r <= CAUSE_IRQ;
        end
      end
    end
  end

  always_comb begin
    trap_mstatus           = mstatus_r;
    trap_mstatus[MPIE_BIT] = mstatus_r[MIE_BIT];
    trap_mstatus[MIE_BIT]  = 1'b0;
    mret_mstatus           = mstatus_r;
    mret_mstatus[MIE_BIT]  = mstatus_r[MPIE_BIT];
    mret_mstatus[MPIE_BIT] = 1'b1;
  end

  // Outputs are pure state decode, except hold which also covers the accept cycle.
  always_comb begin
    csr_we_o            = 1'b0;
    csr_waddr_o         = '0;
    csr_wdata_o         = '0;
    client_hold_flag_o  = 1'b0;
    client_int_assert_o = 1'b0;
    client_int_addr_o   = '0;
    case (state)
      IDLE: begin
        client_hold_flag_o = accept;
      end
      MEPC: begin
        client_hold_flag_o = 1'b1;
        csr_we_o           = 1'b1;
        csr_waddr_o        = ADDR_MEPC;
        csr_wdata_o        = epc_r;
      end
      MSTATUS: begin
        client_hold_flag_o = 1'b1;
        csr_we_o           = 1'b1;
        csr_waddr_o        = ADDR_MSTATUS;
        csr_wdata_o        = trap_mstatus;
      end
      MCAUSE: begin
        client_hold_flag_o = 1'b1;
        csr_we_o           = 1'b1;
        csr_waddr_o        = ADDR_MCAUSE;
        csr_wdata_o        = cause_r;
      end
      ASSERT: begin
        client_int_assert_o = 1'b1;
        client_int_addr_o   = csr_mtvec_i;
      end
      MRET_ST: begin
        client_hold_flag_o = 1'b1;
        csr_we_o           = 1'b1;
        csr_waddr_o        = ADDR_MSTATUS;
        csr_wdata_o        = mret_mstatus;
      end
      MRET_AS: begin
        client_int_assert_o = 1'b1;
        client_int_addr_o   = csr_mepc_i;
      end
      default: begin
        client_hold_flag_o = 1'b0;
      end
    endcase
  end

endmodule
